// File: rtl/vga_cell_fetch_arbiter.sv
// Board colour RAM sequencer: display prefetch has absolute priority, game write/read share the remaining cycles round-robin.
// Optional macro CELL_BORDER_EN overlays BORDER_RGB on the first pixel column/line of every cell.
module vga_cell_fetch_arbiter #(
  parameter int          GRID       = 18,
  parameter int          CELL       = 20,
  parameter int          ADDR_W     = 9,
  parameter int          DATA_W     = 24,
  parameter logic [23:0] BORDER_RGB = 24'h202020
) (
  input  logic              VGA_CLK,
  input  logic              RESET,
  input  logic              VGA_VS,
  input  logic              DISP_EN,
  output logic [DATA_W-1:0] RGB,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_ACK,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_ACK,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic [1:0]        dbg_state
);
  // Handshake: a requester holds REQ and its payload stable; the ACK cycle is the cycle the RAM
  // access happens, and the requester drops (or replaces) its request on the following cycle.
  localparam int XW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int CW = (GRID > 1) ? $clog2(GRID) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(CELL - 1);
  localparam logic [CW-1:0] C_LAST = CW'(GRID - 1);
  localparam logic [CW-1:0] C_PEN  = CW'(GRID - 2);

  typedef enum logic [1:0] {D_IDLE, D_PRE0, D_PRE1, D_ACTIVE} disp_state_t;
  disp_state_t state_q, state_d;

  logic [XW-1:0]     x_cnt_q, y_cnt_q;
  logic [CW-1:0]     col_q, row_q, disp_col;
  logic [DATA_W-1:0] cur_color_q, next_color_q;
  logic              vs_q, de_q, synced_q;
  logic              frame_trig, line_trig;
  logic              disp_rd, disp_rd_en, wr_gnt, rd_gnt;
  logic              last_gnt_rd_q, rd_pend_q, disp_pend_q, disp_to_cur_q;
  logic [ADDR_W-1:0] disp_addr;

  // Line triggers are ignored until a frame start has been seen, so a mid-frame reset stays dark.
  assign frame_trig = vs_q & ~VGA_VS;
  assign line_trig  = synced_q & de_q & ~DISP_EN;
  assign disp_addr  = ADDR_W'(row_q) * ADDR_W'(GRID) + ADDR_W'(disp_col);
  assign disp_rd_en = disp_rd & ~RESET;
  assign dbg_state  = state_q;

  always_comb begin
    state_d  = state_q;
    disp_rd  = 1'b0;
    disp_col = '0;
    case (state_q)
      D_IDLE: ;
      D_PRE0: begin
        disp_rd = 1'b1;
        state_d = D_PRE1;
      end
      D_PRE1: begin
        disp_rd  = 1'b1;
        disp_col = CW'(1);
        state_d  = D_ACTIVE;
      end
      D_ACTIVE: begin
        if (DISP_EN && x_cnt_q == '0 && col_q != '0 && col_q <= C_PEN) begin
          disp_rd  = 1'b1;
          disp_col = col_q + CW'(1);
        end
      end
      default: state_d = D_IDLE;
    endcase
    if (frame_trig || line_trig) state_d = D_PRE0;
  end

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!RESET && !disp_rd) begin
      if (WR_REQ && RD_REQ) begin
        wr_gnt = last_gnt_rd_q;
        rd_gnt = ~last_gnt_rd_q;
      end else begin
        wr_gnt = WR_REQ;
        rd_gnt = RD_REQ;
      end
    end
  end

  always_comb begin
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    if (disp_rd_en) begin
      MEM_ADDR = disp_addr;
    end else if (wr_gnt) begin
      MEM_ADDR  = WR_ADDR;
      MEM_WDATA = WR_DATA;
    end else if (rd_gnt) begin
      MEM_ADDR = RD_ADDR;
    end
  end

  assign MEM_RE   = disp_rd_en | rd_gnt;
  assign MEM_WE   = wr_gnt;
  assign WR_ACK   = wr_gnt;
  assign RD_ACK   = rd_gnt;
  assign RD_VALID = rd_pend_q;
  assign RD_DATA  = rd_pend_q ? MEM_RDATA : '0;

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      state_q       <= D_IDLE;
      vs_q          <= 1'b1;
      de_q          <= 1'b0;
      synced_q      <= 1'b0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      col_q         <= '0;
      row_q         <= '0;
      cur_color_q   <= '0;
      next_color_q  <= '0;
      last_gnt_rd_q <= 1'b1;
      rd_pend_q     <= 1'b0;
      disp_pend_q   <= 1'b0;
      disp_to_cur_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= VGA_VS;
      de_q          <= DISP_EN;
      rd_pend_q     <= rd_gnt;
      disp_pend_q   <= disp_rd_en;
      disp_to_cur_q <= (state_q == D_PRE0);
      if (wr_gnt || rd_gnt) last_gnt_rd_q <= rd_gnt;
      // The PRE0 word is the first cell's colour; every later display read refills next_color.
      if (disp_pend_q) begin
        if (disp_to_cur_q) cur_color_q  <= MEM_RDATA;
        else               next_color_q <= MEM_RDATA;
      end
      if (frame_trig) begin
        synced_q <= 1'b1;
        x_cnt_q  <= '0;
        y_cnt_q  <= '0;
        col_q    <= '0;
        row_q    <= '0;
      end else if (line_trig) begin
        x_cnt_q <= '0;
        col_q   <= '0;
        if (y_cnt_q == X_LAST) begin
          y_cnt_q <= '0;
          if (row_q != C_LAST) row_q <= row_q + CW'(1);
        end else begin
          y_cnt_q <= y_cnt_q + XW'(1);
        end
      end else if (state_q == D_ACTIVE && DISP_EN) begin
        x_cnt_q <= (x_cnt_q == X_LAST) ? '0 : x_cnt_q + XW'(1);
        if (x_cnt_q == X_LAST) begin
          cur_color_q <= next_color_q;
          if (col_q != C_LAST) col_q <= col_q + CW'(1);
        end
      end
    end
  end

`ifdef CELL_BORDER_EN
  assign RGB = (!RESET && DISP_EN && (x_cnt_q == '0 || y_cnt_q == '0)) ? DATA_W'(BORDER_RGB) : cur_color_q;
`else
  logic unused_border;
  assign unused_border = ^BORDER_RGB;
  assign RGB = cur_color_q;
`endif
endmodule

// File: tb/tb_vga_cell_fetch_arbiter.sv
// Randomised bench for vga_cell_fetch_arbiter: a cell/pixel reference model predicts every RAM access and pixel.
// Honours CELL_BORDER_EN the same way as the design.
module tb_vga_cell_fetch_arbiter;
  localparam int GRID   = 18;
  localparam int CELL   = 20;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] BORDER = 24'h202020;

  logic              VGA_CLK = 1'b0;
  logic              RESET, VGA_VS, DISP_EN;
  logic [DATA_W-1:0] RGB, MEM_WDATA, MEM_RDATA, WR_DATA, RD_DATA;
  logic [ADDR_W-1:0] MEM_ADDR, WR_ADDR, RD_ADDR;
  logic              MEM_RE, MEM_WE, WR_REQ, WR_ACK, RD_REQ, RD_ACK, RD_VALID;
  logic [1:0]        dbg_state;

  vga_cell_fetch_arbiter dut (
    .VGA_CLK(VGA_CLK), .RESET(RESET), .VGA_VS(VGA_VS), .DISP_EN(DISP_EN), .RGB(RGB),
    .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_ACK(RD_ACK), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 VGA_CLK = ~VGA_CLK;

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  // single-port RAM the design talks to
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  always @(posedge VGA_CLK) begin
    if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
    if (MEM_RE) MEM_RDATA <= ram[MEM_ADDR];
  end

  // reference model state
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W-1:0] exp_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  bit                chk_en = 1'b0;
  bit                rst_prev = 1'b0;
  bit                m_last_rd = 1'b1;
  bit                m_rd_pend = 1'b0;
  bit                unsynced = 1'b1;
  bit                exp_disp_rd = 1'b0;
  bit                exp_rgb_chk = 1'b0;
  logic [ADDR_W-1:0] exp_disp_addr = '0;
  logic [DATA_W-1:0] exp_rgb = '0;
  bit                wr_ack_s = 1'b0;
  bit                rd_ack_s = 1'b0;
  int                gm_mode = 0;
  int                gm_lo = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int row_of(input int l);
    return (l / CELL > GRID - 1) ? GRID - 1 : l / CELL;
  endfunction

  function automatic logic [DATA_W-1:0] pix_rgb(input int l, input int x);
    int col;
    col = (x / CELL > GRID - 1) ? GRID - 1 : x / CELL;
`ifdef CELL_BORDER_EN
    if (unsynced || x % CELL == 0 || l % CELL == 0) return BORDER;
`else
    if (unsynced) return '0;
`endif
    return ref_mem[row_of(l) * GRID + col];
  endfunction

  // scoreboard: per-cycle prediction of RAM port, acks, read data and pixel
  always @(negedge VGA_CLK) begin
    logic g_wr, g_rd;
    logic [DATA_W-1:0] d;
    g_wr = 1'b0;
    g_rd = 1'b0;
    if (chk_en) begin
      if (RESET) begin
        check_eq("rst_mem_re", {31'b0, MEM_RE}, 0);
        check_eq("rst_mem_we", {31'b0, MEM_WE}, 0);
        check_eq("rst_mem_addr", 32'(MEM_ADDR), 0);
        check_eq("rst_wdata", 32'(MEM_WDATA), 0);
        check_eq("rst_wr_ack", {31'b0, WR_ACK}, 0);
        check_eq("rst_rd_ack", {31'b0, RD_ACK}, 0);
        if (rst_prev) begin
          check_eq("rst_rgb", 32'(RGB), 0);
          check_eq("rst_rd_valid", {31'b0, RD_VALID}, 0);
          check_eq("rst_rd_data", 32'(RD_DATA), 0);
          check_eq("rst_state", 32'(dbg_state), 0);
        end
        m_last_rd = 1'b1;
        m_rd_pend = 1'b0;
        exp_q.delete();
      end else begin
        check_eq("rd_valid", {31'b0, RD_VALID}, {31'b0, m_rd_pend});
        if (m_rd_pend && exp_q.size() > 0) begin
          d = exp_q.pop_front();
          check_eq("rd_data", 32'(RD_DATA), 32'(d));
        end
        if (exp_disp_rd) begin
          check_eq("disp_re", {31'b0, MEM_RE}, 1);
          check_eq("disp_addr", 32'(MEM_ADDR), 32'(exp_disp_addr));
        end else begin
          if (WR_REQ && RD_REQ) begin
            g_wr = m_last_rd;
            g_rd = ~m_last_rd;
          end else begin
            g_wr = WR_REQ;
            g_rd = RD_REQ;
          end
          check_eq("mem_re", {31'b0, MEM_RE}, {31'b0, g_rd});
          if (g_wr) begin
            check_eq("wr_addr", 32'(MEM_ADDR), 32'(WR_ADDR));
            check_eq("wr_data", 32'(MEM_WDATA), 32'(WR_DATA));
          end
          if (g_rd) check_eq("rd_addr", 32'(MEM_ADDR), 32'(RD_ADDR));
        end
        check_eq("mem_we", {31'b0, MEM_WE}, {31'b0, g_wr});
        check_eq("wr_ack", {31'b0, WR_ACK}, {31'b0, g_wr});
        check_eq("rd_ack", {31'b0, RD_ACK}, {31'b0, g_rd});
        if (g_wr) ref_mem[WR_ADDR] = WR_DATA;
        if (g_rd) exp_q.push_back(ref_mem[RD_ADDR]);
        if (g_wr || g_rd) m_last_rd = g_rd;
        m_rd_pend = g_rd;
        if (exp_rgb_chk) check_eq("rgb", 32'(RGB), 32'(exp_rgb));
        if (unsynced) check_eq("idle_state", 32'(dbg_state), 0);
      end
      rst_prev = RESET;
    end
    wr_ack_s = WR_ACK;
    rd_ack_s = RD_ACK;
  end

  // driver: game requesters (hold until ack, then drop or re-request)
  initial begin
    forever begin
      tick();
      if (wr_ack_s) WR_REQ = 1'b0;
      if (rd_ack_s) RD_REQ = 1'b0;
      if (!WR_REQ && gm_mode != 0 && (gm_mode == 2 || $urandom_range(0, 2) == 0)) begin
        WR_REQ  = 1'b1;
        WR_ADDR = ADDR_W'($urandom_range(gm_lo, DEPTH - 1));
        WR_DATA = DATA_W'($urandom());
      end
      if (!RD_REQ && gm_mode != 0 && (gm_mode == 2 || $urandom_range(0, 2) == 0)) begin
        RD_REQ  = 1'b1;
        RD_ADDR = ADDR_W'($urandom_range(gm_lo, DEPTH - 1));
      end
    end
  end

  // driver: one frame of video timing, optionally with a reset pulse inside line rst_line at x=100
  task automatic run_frame(input int nlines, input int rst_line);
    int len, nb;
    VGA_VS = 1'b0; DISP_EN = 1'b0; exp_rgb_chk = 1'b0; exp_disp_rd = 1'b0; unsynced = 1'b0;
    tick();
    exp_disp_rd = 1'b1; exp_disp_addr = ADDR_W'(0);
    tick();
    exp_disp_addr = ADDR_W'(1);
    tick();
    exp_disp_rd = 1'b0; VGA_VS = 1'b1;
    repeat ($urandom_range(1, 3)) tick();
    for (int l = 0; l < nlines; l++) begin
      len = $urandom_range(GRID * CELL, GRID * CELL + 3);
      for (int x = 0; x < len; x++) begin
        DISP_EN = 1'b1;
        if (l == rst_line && (x == 100 || x == 101)) begin
          RESET = 1'b1; unsynced = 1'b1; exp_disp_rd = 1'b0; exp_rgb_chk = 1'b0;
        end else begin
          RESET = 1'b0;
          exp_rgb_chk = 1'b1;
          exp_rgb = pix_rgb(l, x);
          exp_disp_rd = !unsynced && x % CELL == 0 && x / CELL >= 1 && x / CELL <= GRID - 2;
          exp_disp_addr = ADDR_W'(row_of(l) * GRID + x / CELL + 1);
        end
        tick();
      end
      nb = $urandom_range(3, 6);
      for (int h = 0; h < nb; h++) begin
        DISP_EN = 1'b0; exp_rgb_chk = 1'b0;
        exp_disp_rd = !unsynced && (h == 1 || h == 2);
        exp_disp_addr = ADDR_W'(row_of(l + 1) * GRID + ((h == 2) ? 1 : 0));
        tick();
      end
    end
    exp_disp_rd = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    RESET = 1'b1; VGA_VS = 1'b1; DISP_EN = 1'b0;
    WR_REQ = 1'b1; WR_ADDR = ADDR_W'(5); WR_DATA = DATA_W'($urandom());
    RD_REQ = 1'b0; RD_ADDR = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v = DATA_W'($urandom());
      ref_mem[k] = v;
      ram[k] <= v;
    end
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
    gm_mode = 2;
    repeat (10) tick();
    gm_mode = 0;
    repeat (6) tick();
    gm_lo = GRID * GRID;
    gm_mode = 1;
    run_frame(21, -1);
    run_frame(5, 2);
    run_frame(21, -1);
    gm_mode = 0;
    repeat (8) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
